// File: rtl/timer_control.sv
// Countdown timer controller: mm:ss BCD entry, run/pause countdown, timed alarm.
// Buttons are one-cycle pulses resolved by priority clr > start > min > sec.
module timer_control #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned ALARM_SEC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic       btn_start,
    input  logic       btn_clr,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StAlarm = 2'd3
    } state_e;

    localparam int unsigned PreW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned AlmW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(CLK_HZ - 1);
    localparam logic [AlmW-1:0] AlmMax = AlmW'(ALARM_SEC - 1);

    state_e          state_q, state_d;
    logic [3:0]      min_tens_q, min_tens_d;
    logic [3:0]      min_ones_q, min_ones_d;
    logic [3:0]      sec_tens_q, sec_tens_d;
    logic [3:0]      sec_ones_q, sec_ones_d;
    logic [PreW-1:0] prescaler_q, prescaler_d;
    logic [AlmW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic            running_q, running_d;
    logic            alarm_q, alarm_d;

    logic tick;
    logic time_zero;
    logic time_one;
    logic any_btn;

    assign tick      = ((state_q == StRun) || (state_q == StAlarm)) && (prescaler_q == PreMax);
    assign time_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                       (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
    assign time_one  = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                       (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);
    assign any_btn   = btn_clr | btn_start | btn_min | btn_sec;

    always_comb begin
        state_d     = state_q;
        min_tens_d  = min_tens_q;
        min_ones_d  = min_ones_q;
        sec_tens_d  = sec_tens_q;
        sec_ones_d  = sec_ones_q;
        prescaler_d = prescaler_q;
        alarm_cnt_d = alarm_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (btn_clr) begin
                    min_tens_d = 4'd0;
                    min_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    sec_ones_d = 4'd0;
                end else if (btn_start) begin
                    if (!time_zero) begin
                        state_d     = StRun;
                        prescaler_d = '0;
                    end
                end else if (btn_min) begin
                    if (min_ones_q == 4'd9) begin
                        min_ones_d = 4'd0;
                        min_tens_d = (min_tens_q == 4'd9) ? 4'd0 : min_tens_q + 4'd1;
                    end else begin
                        min_ones_d = min_ones_q + 4'd1;
                    end
                end else if (btn_sec) begin
                    // Seconds wrap 59 -> 00 without touching minutes.
                    if (sec_ones_q == 4'd9) begin
                        sec_ones_d = 4'd0;
                        sec_tens_d = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
                    end else begin
                        sec_ones_d = sec_ones_q + 4'd1;
                    end
                end
            end

            StRun: begin
                if (btn_clr) begin
                    state_d     = StIdle;
                    min_tens_d  = 4'd0;
                    min_ones_d  = 4'd0;
                    sec_tens_d  = 4'd0;
                    sec_ones_d  = 4'd0;
                    prescaler_d = '0;
                end else if (btn_start) begin
                    state_d = StPause;
                end else if (tick) begin
                    prescaler_d = '0;
                    if (time_one) begin
                        state_d     = StAlarm;
                        sec_ones_d  = 4'd0;
                        alarm_cnt_d = '0;
                    end else if (sec_ones_q != 4'd0) begin
                        sec_ones_d = sec_ones_q - 4'd1;
                    end else if (sec_tens_q != 4'd0) begin
                        sec_tens_d = sec_tens_q - 4'd1;
                        sec_ones_d = 4'd9;
                    end else begin
                        // ss == 00: borrow a minute.
                        sec_tens_d = 4'd5;
                        sec_ones_d = 4'd9;
                        if (min_ones_q != 4'd0) begin
                            min_ones_d = min_ones_q - 4'd1;
                        end else begin
                            min_ones_d = 4'd9;
                            min_tens_d = min_tens_q - 4'd1;
                        end
                    end
                end else begin
                    prescaler_d = prescaler_q + 1'b1;
                end
            end

            StPause: begin
                if (btn_clr) begin
                    state_d     = StIdle;
                    min_tens_d  = 4'd0;
                    min_ones_d  = 4'd0;
                    sec_tens_d  = 4'd0;
                    sec_ones_d  = 4'd0;
                    prescaler_d = '0;
                end else if (btn_start) begin
                    // Prescaler keeps its partial count across the pause.
                    state_d = StRun;
                end
            end

            StAlarm: begin
                if (any_btn) begin
                    state_d     = StIdle;
                    prescaler_d = '0;
                    alarm_cnt_d = '0;
                end else if (tick) begin
                    prescaler_d = '0;
                    if (alarm_cnt_q == AlmMax) begin
                        state_d     = StIdle;
                        alarm_cnt_d = '0;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + 1'b1;
                    end
                end else begin
                    prescaler_d = prescaler_q + 1'b1;
                end
            end
        endcase

        running_d = (state_d == StRun);
        alarm_d   = (state_d == StAlarm);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            min_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_ones_q  <= 4'd0;
            prescaler_q <= '0;
            alarm_cnt_q <= '0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_tens_q  <= min_tens_d;
            min_ones_q  <= min_ones_d;
            sec_tens_q  <= sec_tens_d;
            sec_ones_q  <= sec_ones_d;
            prescaler_q <= prescaler_d;
            alarm_cnt_q <= alarm_cnt_d;
            running_q   <= running_d;
            alarm_q     <= alarm_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign state    = state_q;
    assign running  = running_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_timer_control.sv
// Directed bench for timer_control with CLK_HZ=4, ALARM_SEC=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_timer_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_min, btn_sec, btn_start, btn_clr;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state;
    logic       running, alarm;

    int n_checks = 0;
    int n_pass   = 0;

    timer_control #(
        .CLK_HZ   (4),
        .ALARM_SEC(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_min  (btn_min),
        .btn_sec  (btn_sec),
        .btn_start(btn_start),
        .btn_clr  (btn_clr),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .state    (state),
        .running  (running),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int tval();
        return int'({min_tens, min_ones, sec_tens, sec_ones});
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0=min 1=sec 2=start 3=clr
    task automatic pulse(input int which, input int times);
        for (int i = 0; i < times; i++) begin
            btn_min   = (which == 0);
            btn_sec   = (which == 1);
            btn_start = (which == 2);
            btn_clr   = (which == 3);
            @(negedge clk);
            btn_min   = 1'b0;
            btn_sec   = 1'b0;
            btn_start = 1'b0;
            btn_clr   = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_min = 1'b0; btn_sec = 1'b0; btn_start = 1'b0; btn_clr = 1'b0;
        step(2);
        rst = 1'b0;
        check("reset_state", state, 0);
        check("reset_time", tval(), 16'h0000);
        check("reset_running", running, 0);
        check("reset_alarm", alarm, 0);

        // Basic countdown with borrow
        pulse(1, 3);
        pulse(0, 1);
        check("set_0103", tval(), 16'h0103);
        pulse(2, 1);
        check("run_state", state, 1);
        check("run_running", running, 1);
        step(3);
        check("no_dec_before_4", tval(), 16'h0103);
        step(1);
        check("first_dec", tval(), 16'h0102);
        step(12);
        check("borrow_0059", tval(), 16'h0059);
        pulse(3, 1);
        check("clr_run_state", state, 0);
        check("clr_run_time", tval(), 16'h0000);

        // Wrap boundaries and zero start
        pulse(1, 59);
        check("sec_59", tval(), 16'h0059);
        pulse(1, 1);
        check("sec_wrap", tval(), 16'h0000);
        pulse(0, 99);
        check("min_99", tval(), 16'h9900);
        pulse(0, 1);
        check("min_wrap", tval(), 16'h0000);
        pulse(2, 1);
        check("start_zero_ignored", state, 0);

        // min beats sec in the same cycle
        btn_min = 1'b1; btn_sec = 1'b1;
        step(1);
        btn_min = 1'b0; btn_sec = 1'b0;
        check("min_over_sec", tval(), 16'h0100);
        pulse(3, 1);
        check("clr_idle", tval(), 16'h0000);

        // Countdown to alarm and auto-return
        pulse(1, 2);
        pulse(2, 1);
        step(3);
        check("alarm_pre", tval(), 16'h0002);
        step(1);
        check("alarm_0001", tval(), 16'h0001);
        step(4);
        check("alarm_time", tval(), 16'h0000);
        check("alarm_state", state, 3);
        check("alarm_flag", alarm, 1);
        check("alarm_not_running", running, 0);
        step(7);
        check("alarm_hold", state, 3);
        step(1);
        check("alarm_done_state", state, 0);
        check("alarm_done_flag", alarm, 0);

        // Pause keeps the prescaler's partial count
        pulse(1, 5);
        pulse(2, 1);
        step(2);
        pulse(2, 1);
        check("pause_state", state, 2);
        check("pause_running", running, 0);
        step(20);
        check("pause_hold_time", tval(), 16'h0005);
        check("pause_hold_state", state, 2);
        pulse(2, 1);
        check("resume_state", state, 1);
        step(1);
        check("resume_no_dec", tval(), 16'h0005);
        step(1);
        check("resume_dec", tval(), 16'h0004);

        // clr beats start
        btn_clr = 1'b1; btn_start = 1'b1;
        step(1);
        btn_clr = 1'b0; btn_start = 1'b0;
        check("clr_over_start_state", state, 0);
        check("clr_over_start_time", tval(), 16'h0000);

        // Button acknowledges alarm without editing time
        pulse(1, 1);
        pulse(2, 1);
        step(4);
        check("ack_in_alarm", state, 3);
        pulse(1, 1);
        check("ack_state", state, 0);
        check("ack_time", tval(), 16'h0000);

        // Reset mid-alarm, with start pulse discarded
        pulse(1, 1);
        pulse(2, 1);
        step(4);
        check("rst_pre_alarm", state, 3);
        rst = 1'b1; btn_start = 1'b1;
        step(1);
        rst = 1'b0; btn_start = 1'b0;
        check("rst_state", state, 0);
        check("rst_alarm", alarm, 0);
        check("rst_time", tval(), 16'h0000);
        step(1);
        check("rst_after_state", state, 0);

        // Reset mid-run with nonzero time
        pulse(1, 3);
        pulse(2, 1);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_run_state", state, 0);
        check("rst_run_running", running, 0);
        check("rst_run_time", tval(), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
